// File: rtl/crypto_run_sequencer.sv
// crypto_run_sequencer
//   Runs the crypto core a programmable number of times per go request, with
//   an idle gap between runs, latches the ciphertext after each completed run,
//   and raises a sticky watchdog error if the core fails to respond.
//
// Ports
//   clk, rst      sole clock; synchronous active-high reset
//   go, abort     sequence start request / early termination
//   repeat_cnt    runs per sequence (0 behaves as 1), captured at go
//   gap_cycles    idle cycles between runs, captured at go
//   core_start    one-cycle start pulse to the core
//   core_busy     core busy flag; core_ct is valid on its falling edge
//   core_ct       core ciphertext
//   ct_out        ciphertext of the last completed run
//   runs_done     runs completed in the current/last sequence
//   ready         high only while idle
//   done          one-cycle pulse when a sequence ends
//   timeout_err   sticky watchdog error, cleared by the next accepted go
//   trigger       registered scope trigger (core wait/run, one cycle late)
//   dbg_state     current FSM state for checkers
//
// Handshake: go is accepted on a clock edge where go=1 and ready=1; go while
// ready=0 is dropped, nothing is queued.
module crypto_run_sequencer #(
    parameter int CT_WIDTH       = 128,
    parameter int CNT_WIDTH      = 16,
    parameter int BUSY_WAIT      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] repeat_cnt,
    input  logic [CNT_WIDTH-1:0] gap_cycles,
    output logic                 core_start,
    input  logic                 core_busy,
    input  logic [CT_WIDTH-1:0]  core_ct,
    output logic [CT_WIDTH-1:0]  ct_out,
    output logic [CNT_WIDTH-1:0] runs_done,
    output logic                 ready,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 trigger,
    output logic [2:0]           dbg_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    // Wait and watchdog counters count 0 .. limit-1.
    localparam int WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] target_q, target_d;
    logic [CNT_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] runs_done_q, runs_done_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [CT_WIDTH-1:0]  ct_out_q, ct_out_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 trigger_q, trigger_d;
    logic [CNT_WIDTH-1:0] runs_next;

    assign runs_next = runs_done_q + CNT_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt_q;
        runs_done_d   = runs_done_q;
        wait_cnt_d    = wait_cnt_q;
        wdog_d        = wdog_q;
        ct_out_d      = ct_out_q;
        timeout_err_d = timeout_err_q;
        trigger_d     = (state_q == S_WAIT_BUSY) || (state_q == S_RUN);

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    target_d      = (repeat_cnt == '0) ? CNT_WIDTH'(1) : repeat_cnt;
                    gap_d         = gap_cycles;
                    runs_done_d   = '0;
                    timeout_err_d = 1'b0;
                    state_d       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = abort ? S_FINISH : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else if (core_busy) begin
                    wdog_d  = '0;
                    state_d = S_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FINISH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_RUN: begin
                if (!core_busy) begin
                    // A completed run is always recorded, even when abort
                    // arrives on the same cycle.
                    ct_out_d    = core_ct;
                    runs_done_d = runs_next;
                    if (abort || (runs_next == target_q)) begin
                        state_d = S_FINISH;
                    end else if (gap_q == '0) begin
                        state_d = S_LAUNCH;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end
                end else if (abort) begin
                    state_d = S_FINISH;
                end else if (wdog_q == WDOG_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FINISH;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else if (gap_cnt_q == (gap_q - CNT_WIDTH'(1))) begin
                    state_d = S_LAUNCH;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            target_q      <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            runs_done_q   <= '0;
            wait_cnt_q    <= '0;
            wdog_q        <= '0;
            ct_out_q      <= '0;
            timeout_err_q <= 1'b0;
            trigger_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            runs_done_q   <= runs_done_d;
            wait_cnt_q    <= wait_cnt_d;
            wdog_q        <= wdog_d;
            ct_out_q      <= ct_out_d;
            timeout_err_q <= timeout_err_d;
            trigger_q     <= trigger_d;
        end
    end

    assign core_start  = (state_q == S_LAUNCH);
    assign ready       = (state_q == S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign ct_out      = ct_out_q;
    assign runs_done   = runs_done_q;
    assign timeout_err = timeout_err_q;
    assign trigger     = trigger_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_crypto_run_sequencer.sv
// Bench for crypto_run_sequencer. A behavioural core answers each core_start
// with a per-run profile (rise delay, busy length, ciphertext); a timeline
// model predicts start cycles, done cycle, trigger cycles and final results.
`timescale 1ns/1ps
module tb_crypto_run_sequencer;
    localparam int CT_W  = 128;
    localparam int CNT_W = 16;
    localparam int BW    = 8;
    localparam int TO    = 40;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst, go, abort, core_busy;
    logic [CNT_W-1:0] repeat_cnt, gap_cycles, runs_done;
    logic [CT_W-1:0]  core_ct, ct_out;
    logic             core_start, ready, done, timeout_err, trigger;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    crypto_run_sequencer #(
        .CT_WIDTH(CT_W), .CNT_WIDTH(CNT_W), .BUSY_WAIT(BW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .repeat_cnt(repeat_cnt), .gap_cycles(gap_cycles),
        .core_start(core_start), .core_busy(core_busy), .core_ct(core_ct),
        .ct_out(ct_out), .runs_done(runs_done), .ready(ready), .done(done),
        .timeout_err(timeout_err), .trigger(trigger), .dbg_state(dbg_state)
    );

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int prof_r[8];
    int prof_l[8];
    logic [CT_W-1:0] prof_ct[8];
    int core_idx, rise_at, fall_at;
    logic [CT_W-1:0] cur_ct;
    bit go_req, abort_req, rst_req;
    logic [31:0] exp_q[$];
    int obs_starts[$];
    bit act[int];
    int exp_finish, exp_runs;
    bit exp_terr;
    logic [CT_W-1:0] exp_ct;
    int done_cnt, done_cyc, trig_err;
    bit ready_at_done;

    task automatic chk(input string tag, input logic [CT_W-1:0] got, input logic [CT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [CT_W-1:0] rand_ct();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        bit et;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        go = go_req; abort = abort_req; rst = rst_req;
        go_req = 1'b0; abort_req = 1'b0; rst_req = 1'b0;
        if (cyc == rise_at) core_busy = 1'b1;
        if (cyc == fall_at) begin
            core_busy = 1'b0;
            core_ct   = cur_ct;
        end else if (cyc == fall_at + 1) begin
            core_ct = rand_ct();
        end
        @(negedge clk);
        if (core_start) begin
            obs_starts.push_back(cyc);
            if (core_idx < 8) begin
                rise_at = cyc + prof_r[core_idx];
                fall_at = cyc + prof_r[core_idx] + prof_l[core_idx];
                cur_ct  = prof_ct[core_idx];
            end
            core_idx++;
        end
        if (done) begin
            done_cnt++;
            done_cyc      = cyc;
            ready_at_done = ready;
        end
        et = act.exists(cyc - 1) ? 1'b1 : 1'b0;
        if (trigger !== et) trig_err++;
    endtask

    task automatic set_prof(input int i, input int r, input int l);
        prof_r[i]  = r;
        prof_l[i]  = l;
        prof_ct[i] = rand_ct();
    endtask

    // ---------------- reference timeline model ----------------
    // Start at s; busy rises in cycle s+r and stays high l cycles; the core is
    // waited on / running in cycles s+1 .. end of run; trigger follows one
    // cycle later. Abort in cycle ab ends the sequence at ab+1.
    task automatic model(input int g, input int rep, input int gp, input int ab);
        int target, s, r, l, e;
        target = (rep == 0) ? 1 : rep;
        exp_q.delete();
        act.delete();
        exp_runs = 0; exp_terr = 1'b0; exp_finish = -1;
        s = g + 1;
        for (int i = 0; i < target; i++) begin
            if (ab >= 0 && ab < s) begin
                exp_finish = ab + 1;
                break;
            end
            exp_q.push_back(s);
            r = prof_r[i]; l = prof_l[i];
            if (r > BW)      e = s + BW;
            else if (l > TO) e = s + r + TO;
            else             e = s + r + l;
            if (ab >= 0 && ab <= e) begin
                for (int c = s + 1; c <= ab; c++) act[c] = 1'b1;
                if (r <= BW && l <= TO && ab == e) begin
                    exp_runs++;
                    exp_ct = prof_ct[i];
                end
                exp_finish = ab + 1;
                break;
            end
            for (int c = s + 1; c <= e; c++) act[c] = 1'b1;
            if (r > BW || l > TO) begin
                exp_terr   = 1'b1;
                exp_finish = e + 1;
                break;
            end
            exp_runs++;
            exp_ct = prof_ct[i];
            if (exp_runs == target) begin
                exp_finish = e + 1;
                break;
            end
            s = e + 1 + gp;
        end
    endtask

    // ---------------- one sequence + scoreboard ----------------
    task automatic run_seq(input int rep, input int gp, input int ab_off, input bit stray);
        int g, ab, budget;
        g  = cyc + 1;
        ab = (ab_off >= 0) ? g + ab_off : -1;
        model(g, rep, gp, ab);
        obs_starts.delete();
        core_idx = 0; rise_at = -100; fall_at = -100; core_busy = 1'b0;
        done_cnt = 0; done_cyc = -1; trig_err = 0;
        repeat_cnt = CNT_W'(rep);
        gap_cycles = CNT_W'(gp);
        go_req = 1'b1;
        step();                                   // cycle g: go accepted
        if (ab == g + 1) abort_req = 1'b1;
        step();                                   // cycle g+1: launch
        chk("start_lat", core_start, 1);
        chk("terr_clr", timeout_err, 0);
        chk("runs_clr", runs_done, 0);
        chk("ready_busy", ready, 0);
        repeat_cnt = CNT_W'($urandom_range(0, 7));   // must have no effect now
        gap_cycles = CNT_W'($urandom_range(0, 9));
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            if (cyc + 1 == ab) abort_req = 1'b1;
            if (stray && cyc + 1 == g + 2) go_req = 1'b1;
            step();
            budget++;
        end
        chk("done_seen", done_cnt != 0, 1);
        chk("done_cyc", done_cyc, exp_finish);
        chk("ready_fin", ready_at_done, 0);
        chk("runs_done", runs_done, exp_runs);
        chk("ct_out", ct_out, exp_ct);
        chk("timeout_err", timeout_err, exp_terr);
        step();
        step();
        chk("ready_idle", ready, 1);
        chk("done_pulses", done_cnt, 1);
        chk("n_starts", obs_starts.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_starts.size() > 0)
            chk("start_cyc", obs_starts.pop_front(), exp_q.pop_front());
        chk("trigger", trig_err, 0);
    endtask

    // ---------------- main ----------------
    initial begin
        rst = 1'b1; go = 1'b0; abort = 1'b0; core_busy = 1'b0;
        repeat_cnt = '0; gap_cycles = '0; core_ct = '0; cur_ct = '0;
        rise_at = -100; fall_at = -100; core_idx = 0; exp_ct = '0;
        go_req = 1'b0; abort_req = 1'b0; rst_req = 1'b0;
        repeat (3) begin rst_req = 1'b1; step(); end
        step();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_start", core_start, 0);
        chk("rst_trigger", trigger, 0);
        chk("rst_runs", runs_done, 0);
        chk("rst_ct", ct_out, 0);
        chk("rst_terr", timeout_err, 0);

        // abort while idle is ignored
        done_cnt = 0;
        abort_req = 1'b1; step(); step();
        chk("idle_abort_ready", ready, 1);
        chk("idle_abort_done", done_cnt, 0);

        set_prof(0, 2, 10);                          run_seq(1, 0, -1, 0);
        for (int i = 0; i < 3; i++) set_prof(i, $urandom_range(1, 4), $urandom_range(2, 8));
        run_seq(3, 5, -1, 1);
        set_prof(0, 3, 4);                           run_seq(0, 3, -1, 0);
        for (int i = 0; i < 4; i++) set_prof(i, $urandom_range(1, 3), $urandom_range(1, 5));
        run_seq(4, 0, -1, 0);
        set_prof(0, BW, 3); set_prof(1, 1, 1);       run_seq(2, 1, -1, 0);   // latest busy rise accepted
        set_prof(0, BW + 1, 2);                      run_seq(2, 0, -1, 0);   // busy never rises in time
        set_prof(0, 1, TO);                          run_seq(1, 0, -1, 1);   // longest busy accepted
        set_prof(0, 2, TO + 1);                      run_seq(1, 0, -1, 0);   // busy stuck high
        set_prof(0, 2, 3); set_prof(1, 1, 2);        run_seq(2, 2, -1, 0);   // go after error
        for (int i = 0; i < 5; i++) set_prof(i, 2, 6);
        run_seq(5, 3, 16, 1);                        // abort during run 2 of 5

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++)
                set_prof(i,
                         ($urandom_range(0, 9) == 0) ? BW + $urandom_range(1, 3) : $urandom_range(1, BW),
                         ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(1, 12));
            run_seq($urandom_range(0, 5), $urandom_range(0, 6),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : -1,
                    1'($urandom_range(0, 1)));
        end

        // reset while a run is in progress
        for (int i = 0; i < 3; i++) set_prof(i, 2, 6);
        model(cyc + 1, 3, 2, -1);
        core_idx = 0; rise_at = -100; fall_at = -100; trig_err = 0;
        repeat_cnt = 3; gap_cycles = 2; go_req = 1'b1;
        step();
        repeat (5) step();                           // now in the run phase
        chk("pre_rst_trigger", trigger, 1);
        rst_req = 1'b1; step();
        act.delete();
        step();
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_trigger", trigger, 0);
        chk("mid_rst_start", core_start, 0);
        chk("mid_rst_runs", runs_done, 0);
        chk("mid_rst_done", done, 0);
        chk("trigger_pre_rst", trig_err, 0);
        exp_ct = '0;
        rise_at = -100; fall_at = -100; core_busy = 1'b0;
        step();
        set_prof(0, 1, 3);                           run_seq(1, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
